// File: rtl/can_crc15_engine.sv
// CAN CRC-15 engine: MSB-first words with partial final word, STEP bits per cycle.
// Optional zero-residue check (crc_ok) compiled in with `define CAN_CRC15_CHECK_EN.
module can_crc15_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STEP   = 1,
    parameter logic [14:0] POLY   = 15'h4599,
    parameter logic [14:0] INIT   = 15'h0000,
    localparam int unsigned NB_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NB_W-1:0]   in_nbits,
    input  logic              in_last,
    output logic [14:0]       crc_out,
    output logic              crc_valid,
    output logic              crc_ok,
    output logic              busy
);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e            state_q, state_d;
    logic [14:0]       crc_q, crc_d, crc_chain;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NB_W-1:0]   rem_q, rem_d, take, nbits_clamp;
    logic              last_q, last_d;
    logic              first_pend_q, first_pend_d;
    logic              crc_valid_q;
    logic              done;

    assign nbits_clamp = (in_nbits > NB_W'(DATA_W)) ? NB_W'(DATA_W) : in_nbits;
    assign take        = (rem_q > NB_W'(STEP)) ? NB_W'(STEP) : rem_q;

    // Unrolled chain: bits beyond the remaining count leave the accumulator untouched.
    always_comb begin
        crc_chain = crc_q;
        for (int i = 0; i < int'(STEP); i++) begin
            if (i < int'(rem_q)) begin
                crc_chain = {crc_chain[13:0], 1'b0}
                          ^ ((data_q[DATA_W-1-i] ^ crc_chain[14]) ? POLY : 15'h0000);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_d      = state_q;
        crc_d        = crc_q;
        data_d       = data_q;
        rem_d        = rem_q;
        last_d       = last_q;
        first_pend_d = first_pend_q;
        done         = 1'b0;
        if (clr) begin
            state_d      = IDLE;
            crc_d        = INIT;
            first_pend_d = 1'b1;
            rem_d        = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_d       = in_data;
                        rem_d        = nbits_clamp;
                        last_d       = in_last;
                        first_pend_d = 1'b0;
                        if (first_pend_q) crc_d = INIT;
                        if (nbits_clamp != '0) begin
                            state_d = SHIFT;
                        end else if (in_last) begin
                            done         = 1'b1;
                            first_pend_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    crc_d  = crc_chain;
                    data_d = data_q << STEP;
                    rem_d  = rem_q - take;
                    if (rem_q <= NB_W'(STEP)) begin
                        state_d = IDLE;
                        if (last_q) begin
                            done         = 1'b1;
                            first_pend_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            crc_q        <= INIT;
            data_q       <= '0;
            rem_q        <= '0;
            last_q       <= 1'b0;
            first_pend_q <= 1'b1;
            crc_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            data_q       <= data_d;
            rem_q        <= rem_d;
            last_q       <= last_d;
            first_pend_q <= first_pend_d;
            crc_valid_q  <= done;
        end
    end

`ifdef CAN_CRC15_CHECK_EN
    logic crc_ok_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_ok_q <= 1'b0;
        else     crc_ok_q <= done && (crc_d == 15'h0000);
    end

    assign crc_ok = crc_ok_q;
`else
    assign crc_ok = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) && !clr;
    assign busy      = (state_q == SHIFT);
    assign crc_out   = crc_q;
    assign crc_valid = crc_valid_q;

endmodule

// File: tb/tb_can_crc15_engine.sv
// Directed bench for can_crc15_engine: one STEP=1 and one STEP=4 instance sharing inputs.
module tb_can_crc15_engine;

`ifdef CAN_CRC15_CHECK_EN
    localparam logic EXP_OK = 1'b1;
`else
    localparam logic EXP_OK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, clr, v1, v4, last;
    logic [31:0] data;
    logic [5:0]  nbits;
    logic        ready1, cv1, ok1, busy1;
    logic        ready4, cv4, ok4, busy4;
    logic [14:0] crc1, crc4;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    can_crc15_engine #(.DATA_W(32), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(v1), .in_ready(ready1),
        .in_data(data), .in_nbits(nbits), .in_last(last), .crc_out(crc1),
        .crc_valid(cv1), .crc_ok(ok1), .busy(busy1)
    );

    can_crc15_engine #(.DATA_W(32), .STEP(4)) u4 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(v4), .in_ready(ready4),
        .in_data(data), .in_nbits(nbits), .in_last(last), .crc_out(crc4),
        .crc_valid(cv4), .crc_ok(ok4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word to the chosen instance and counts cycles with in_ready low.
    task automatic offer(input bit sel, input logic [31:0] d, input logic [5:0] n,
                         input logic l, output int cyc);
        data  = d;
        nbits = n;
        last  = l;
        if (sel) v4 = 1'b1; else v1 = 1'b1;
        tick();
        v1  = 1'b0;
        v4  = 1'b0;
        cyc = 0;
        while (((sel ? ready4 : ready1) == 1'b0) && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; v1 = 1'b0; v4 = 1'b0;
        data = '0; nbits = '0; last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (crc1 !== 15'h0000) begin n_fail++; $display("FAIL reset_crc: got %h want 0000", crc1); end
        n_cmp++; if ({cv1, ok1, busy1, ready1} !== 4'b0001) begin n_fail++; $display("FAIL reset_flags: got %b want 0001", {cv1, ok1, busy1, ready1}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_bit();
        int cyc;
        offer(1'b0, 32'h8000_0000, 6'd1, 1'b1, cyc);
        n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL t1_busy_cycles: got %0d want 1", cyc); end
        n_cmp++; if (crc1 !== 15'h4599) begin n_fail++; $display("FAIL t1_crc: got %h want 4599", crc1); end
        n_cmp++; if ({cv1, ok1} !== 2'b10) begin n_fail++; $display("FAIL t1_valid_ok: got %b want 10", {cv1, ok1}); end
        tick();
        n_cmp++; if ({cv1, crc1} !== {1'b0, 15'h4599}) begin n_fail++; $display("FAIL t1_hold: got %b/%h want 0/4599", cv1, crc1); end
    endtask

    task automatic test_two_bits();
        int cyc;
        offer(1'b0, 32'h8000_0000, 6'd2, 1'b1, cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL t2_ready_low: got %0d want 2", cyc); end
        n_cmp++; if ({cv1, crc1} !== {1'b1, 15'h4EAB}) begin n_fail++; $display("FAIL t2_crc: got %b/%h want 1/4eab", cv1, crc1); end
    endtask

    task automatic test_residue_step4();
        int cyc;
        offer(1'b1, 32'h8000_0000, 6'd1, 1'b0, cyc);
        n_cmp++; if ({cyc, cv4, crc4} !== {32'd1, 1'b0, 15'h4599}) begin n_fail++; $display("FAIL t3_word1: got %0d/%b/%h want 1/0/4599", cyc, cv4, crc4); end
        offer(1'b1, 32'h8B32_0000, 6'd15, 1'b1, cyc);
        n_cmp++; if (cyc !== 4) begin n_fail++; $display("FAIL t3_cycles: got %0d want 4", cyc); end
        n_cmp++; if ({cv4, ok4, crc4} !== {1'b1, EXP_OK, 15'h0000}) begin n_fail++; $display("FAIL t3_residue: got %b/%b/%h want 1/%b/0000", cv4, ok4, crc4, EXP_OK); end
        tick();
        n_cmp++; if ({cv4, ok4} !== 2'b00) begin n_fail++; $display("FAIL t3_pulse: got %b want 00", {cv4, ok4}); end
    endtask

    task automatic test_clamp();
        int cyc;
        offer(1'b1, 32'h0000_C599, 6'd63, 1'b1, cyc);
        n_cmp++; if (cyc !== 8) begin n_fail++; $display("FAIL clamp_cycles: got %0d want 8", cyc); end
        n_cmp++; if ({cv4, ok4, crc4} !== {1'b1, EXP_OK, 15'h0000}) begin n_fail++; $display("FAIL clamp_crc: got %b/%b/%h want 1/%b/0000", cv4, ok4, crc4, EXP_OK); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        for (int m = 0; m < 2; m++) begin
            offer(1'b0, 32'h8000_0000, 6'd1, 1'b1, cyc);
            n_cmp++; if ({cyc, cv1, crc1} !== {32'd1, 1'b1, 15'h4599}) begin n_fail++; $display("FAIL b2b_msg%0d: got %0d/%b/%h want 1/1/4599", m, cyc, cv1, crc1); end
        end
    endtask

    task automatic test_clr();
        data = 32'hFFFF_FFFF; nbits = 6'd32; last = 1'b1; v1 = 1'b1;
        tick();
        tick();
        n_cmp++; if ({busy1, crc1} !== {1'b1, 15'h4599}) begin n_fail++; $display("FAIL clr_pre: got %b/%h want 1/4599", busy1, crc1); end
        clr = 1'b1;
        #1;
        n_cmp++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b want 0", ready1); end
        tick();
        clr = 1'b0;
        v1  = 1'b0;
        n_cmp++; if ({busy1, cv1, crc1} !== {1'b0, 1'b0, 15'h0000}) begin n_fail++; $display("FAIL clr_after: got %b/%b/%h want 0/0/0000", busy1, cv1, crc1); end
        tick();
        n_cmp++; if ({busy1, cv1, ready1} !== 3'b001) begin n_fail++; $display("FAIL clr_no_accept: got %b want 001", {busy1, cv1, ready1}); end
    endtask

    task automatic test_zero_bits();
        int cyc;
        offer(1'b0, 32'hDEAD_BEEF, 6'd0, 1'b1, cyc);
        n_cmp++; if ({cyc, busy1} !== {32'd0, 1'b0}) begin n_fail++; $display("FAIL zero_noshift: got %0d/%b want 0/0", cyc, busy1); end
        n_cmp++; if ({cv1, ok1, crc1} !== {1'b1, EXP_OK, 15'h0000}) begin n_fail++; $display("FAIL zero_valid: got %b/%b/%h want 1/%b/0000", cv1, ok1, crc1, EXP_OK); end
    endtask

    task automatic test_async_reset();
        data = 32'hFFFF_FFFF; nbits = 6'd32; last = 1'b1; v1 = 1'b1;
        tick();
        v1 = 1'b0;
        tick();
        tick();
        n_cmp++; if (busy1 !== 1'b1 || crc1 === 15'h0000) begin n_fail++; $display("FAIL rst_pre: got %b/%h want busy 1 with nonzero crc", busy1, crc1); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({busy1, cv1, ok1, ready1, crc1} !== {4'b0001, 15'h0000}) begin n_fail++; $display("FAIL rst_async: got %b%b%b%b/%h want 0001/0000", busy1, cv1, ok1, ready1, crc1); end
        #1 rst = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++; if ({busy1, cv1} !== 2'b00) begin n_fail++; $display("FAIL rst_no_valid: got %b want 00", {busy1, cv1}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_two_bits();
        test_residue_step4();
        test_clamp();
        test_back_to_back();
        test_clr();
        test_zero_bits();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
